// File: rtl/wolfram_ca_engine_if.sv
// Control/data bundle for the elementary cellular-automaton engine.
// master drives loads and run control; slave (the engine) returns cells and status.
interface wolfram_ca_engine_if #(
  parameter int WIDTH = 16,
  parameter int GEN_W = 8
);
  logic [7:0]       rule_in;
  logic             rule_load;
  logic [WIDTH-1:0] seed_in;
  logic             seed_load;
  logic             boundary;
  logic [GEN_W-1:0] run_count;
  logic             start;
  logic             halt;
  logic [WIDTH-1:0] state_out;
  logic [GEN_W-1:0] gen_count;
  logic             busy;
  logic             done;

  modport master (
    output rule_in, rule_load, seed_in, seed_load, boundary, run_count, start, halt,
    input  state_out, gen_count, busy, done
  );

  modport slave (
    input  rule_in, rule_load, seed_in, seed_load, boundary, run_count, start, halt,
    output state_out, gen_count, busy, done
  );
endinterface

// File: rtl/wolfram_ca_engine.sv
// Elementary (radius-1) cellular automaton: one generation per RUN cycle, N-cycle run then a done pulse.
// No backpressure; loads and start are only honoured in IDLE, halt aborts a run without a done pulse.
module wolfram_ca_engine #(
  parameter int WIDTH = 16,
  parameter int GEN_W = 8
) (
  input logic               clk,
  input logic               reset,
  wolfram_ca_engine_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cells;
  logic [7:0]       r_rule;
  logic [GEN_W-1:0] r_gen;
  logic [GEN_W-1:0] r_target;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_next;
  logic [GEN_W-1:0] w_gen_inc;
  logic             w_load;

  assign w_gen_inc = r_gen + GEN_W'(1);
  assign w_load    = bus.rule_load | bus.seed_load;

  // Edge cells see either the opposite edge (periodic) or a constant 0 (null boundary).
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    logic w_l;
    logic w_r;
    if (gi == WIDTH - 1) begin : g_left_edge
      assign w_l = bus.boundary ? 1'b0 : r_cells[0];
    end else begin : g_left_in
      assign w_l = r_cells[gi+1];
    end
    if (gi == 0) begin : g_right_edge
      assign w_r = bus.boundary ? 1'b0 : r_cells[WIDTH-1];
    end else begin : g_right_in
      assign w_r = r_cells[gi-1];
    end
    assign w_next[gi] = r_rule[{w_l, r_cells[gi], w_r}];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cells  <= '0;
      r_rule   <= '0;
      r_gen    <= '0;
      r_target <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.rule_load) r_rule  <= bus.rule_in;
          if (bus.seed_load) r_cells <= bus.seed_in;
          if (!w_load && bus.start) begin
            r_gen <= '0;
            if (bus.run_count != '0) begin
              r_target <= bus.run_count;
              r_state  <= S_RUN;
              r_busy   <= 1'b1;
            end else begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Halt wins over completion: the generation in flight is discarded.
          if (bus.halt) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cells <= w_next;
            r_gen   <= w_gen_inc;
            if (w_gen_inc == r_target) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state_out = r_cells;
  assign bus.gen_count = r_gen;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: doc/wolfram_ca_engine.md
WOLFRAM_CA_ENGINE -- requirements
Module: wolfram_ca_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of cells (min 3).
REQ-002 SHALL have parameter GEN_W, default 8, width of the generation counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rule_in  input  8  elementary-CA rule number.
REQ-006 SHALL have port rule_load  input  1  capture rule_in into the rule register.
REQ-007 SHALL have port seed_in  input  WIDTH  initial cell pattern.
REQ-008 SHALL have port seed_load  input  1  capture seed_in into the cell register.
REQ-009 SHALL have port boundary  input  1  0 = periodic wrap, 1 = null (cells outside the array read 0); sampled every RUN cycle.
REQ-010 SHALL have port run_count  input  GEN_W  number of generations to compute; sampled at start.
REQ-011 SHALL have port start  input  1  begin a run.
REQ-012 SHALL have port halt  input  1  abort a run in progress.
REQ-013 SHALL have port state_out  output  WIDTH  current cell register.
REQ-014 SHALL have port gen_count  output  GEN_W  generations completed in the current/last run.
REQ-015 SHALL have port busy  output  1  high while in RUN.
REQ-016 SHALL have port done  output  1  one-cycle pulse at run completion.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-018 Neighbourhood of cell i SHALL be index = {c[i+1], c[i], c[i-1]} (bit WIDTH-1 is leftmost); next c[i] = rule[index].
REQ-019 Under boundary=0, c[WIDTH] SHALL read c[0] and c[-1] SHALL read c[WIDTH-1]; under boundary=1 both read 0.
REQ-020 All WIDTH cells SHALL update simultaneously, one generation per RUN cycle.
REQ-021 In IDLE, rule_load and seed_load SHALL capture their inputs at the clock edge; both may load in the same cycle.
REQ-022 In IDLE, if seed_load or rule_load is high, start SHALL be ignored that cycle (load has priority).
REQ-023 In IDLE with start=1 and run_count>0: latch run_count, clear gen_count to 0, enter RUN.
REQ-024 In IDLE with start=1 and run_count=0: clear gen_count, enter DONE directly; cells unchanged.
REQ-025 In RUN each cycle: update cells, gen_count+1; when the incremented value equals the latched count, enter DONE.
REQ-026 done SHALL be 1 exactly in the DONE cycle; DONE SHALL return to IDLE on the next edge.
REQ-027 busy SHALL be 1 exactly while in RUN; run of N generations: busy high N cycles, then done for 1 cycle.
REQ-028 halt in RUN SHALL return to IDLE at that edge without updating cells or gen_count and without done; halt has priority over completion.
REQ-029 halt in IDLE or DONE SHALL have no effect.
REQ-030 start, rule_load, seed_load in RUN or DONE SHALL be ignored.
REQ-031 state_out and gen_count SHALL hold their values in IDLE after a run until the next load/start.

Reset
REQ-032 reset SHALL immediately force state IDLE, cells=0, rule=0, gen_count=0, latched count=0, busy=0, done=0, regardless of clock or FSM state.
REQ-033 After reset deassertion the block SHALL accept loads/start on the first following rising edge.

Verification
REQ-034 WIDTH=8, rule 0x5A, seed 0x08, boundary 0, run_count 1 -> state_out 0x14, gen_count 1, busy 1 cycle, done 1 cycle.
REQ-035 WIDTH=8, rule 0x5A, seed 0x01, run_count 1: boundary 0 -> 0x82; boundary 1 -> 0x02.
REQ-036 rule 0xCC, any seed 0xA5, run_count 5 -> state_out 0xA5, gen_count 5, busy exactly 5 cycles; run_count 0 -> done next cycle, busy never high.
REQ-037 rule 0x5A, seed 0x08, run_count 10, halt asserted in 3rd RUN cycle -> gen_count 2, state_out 0x22, no done pulse, FSM IDLE.
REQ-038 Assert reset mid-run (gen_count 3 of 10) -> all outputs 0 asynchronously; subsequent seed_load+start runs normally; start with seed_load high same cycle -> seed loaded, no run.
